emir_getirici: RTL and testbench

//  Instruction-fetch stage placed directly upstream of the MESS core. Holds a small

---
 rtl/emir_getirici.sv | 111 +++++++++++
 tb/tb_emir_getirici.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/emir_getirici.sv
// Instruction-fetch stage ahead of MESS: loadable program memory plus program counter.
// Issues one emir per unstalled clock and drives the idle word 0 whenever nothing is issued.
//
//  state | meaning
//  BOS   | idle after reset; program may be loaded; waiting for basla
//  CALIS | issuing mem[pc] each unstalled cycle; memory write-protected
//  BITTI | program ended without wrap; bitti held high; loadable; restartable
module emir_getirici #(
    parameter int ADRES_W = 4,
    parameter int EMIR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               yukle_en,
    input  logic [ADRES_W-1:0] yukle_adres,
    input  logic [EMIR_W-1:0]  yukle_veri,
    input  logic [ADRES_W:0]   program_uzunlugu,
    input  logic               basla,
    input  logic               tekrar,
    input  logic               dur,
    output logic [EMIR_W-1:0]  emir,
    output logic               emir_gecerli,
    output logic [ADRES_W-1:0] pc,
    output logic               bitti
);

    localparam int DERINLIK_INT = 2 ** ADRES_W;
    localparam logic [ADRES_W:0] DERINLIK = (ADRES_W + 1)'(DERINLIK_INT);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        CALIS = 2'd1,
        BITTI = 2'd2
    } durum_t;

    durum_t durum;

    logic [EMIR_W-1:0]  mem [DERINLIK_INT];
    logic [ADRES_W:0]   uzunluk_q;
    logic [ADRES_W:0]   uzunluk_giris;
    logic [ADRES_W:0]   son_adres_genis;
    logic [ADRES_W-1:0] son_adres;
    logic               yazma_izni;
    logic               baslat;

    // Lengths beyond the memory depth saturate to a full-memory program.
    assign uzunluk_giris   = (program_uzunlugu > DERINLIK) ? DERINLIK : program_uzunlugu;
    assign son_adres_genis = uzunluk_q - 1'b1;
    assign son_adres       = son_adres_genis[ADRES_W-1:0];
    assign yazma_izni      = yukle_en && (durum != CALIS);
    assign baslat          = basla && (uzunluk_giris != '0) && (durum != CALIS);

    // The program store is never reset; it keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (yazma_izni) begin
            mem[yukle_adres] <= yukle_veri;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum        <= BOS;
            pc           <= '0;
            emir         <= '0;
            emir_gecerli <= 1'b0;
            bitti        <= 1'b0;
            uzunluk_q    <= '0;
        end else begin
            case (durum)
                BOS, BITTI: begin
                    emir         <= '0;
                    emir_gecerli <= 1'b0;
                    if (baslat) begin
                        uzunluk_q <= uzunluk_giris;
                        pc        <= '0;
                        bitti     <= 1'b0;
                        durum     <= CALIS;
                    end
                end
                CALIS: begin
                    if (dur) begin
                        emir         <= '0;
                        emir_gecerli <= 1'b0;
                    end else begin
                        emir         <= mem[pc];
                        emir_gecerli <= 1'b1;
                        // Wrap uses the explicit last-address compare so a full-depth
                        // program does not depend on counter overflow.
                        if (pc == son_adres) begin
                            pc <= '0;
                            if (!tekrar) begin
                                bitti <= 1'b1;
                                durum <= BITTI;
                            end
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                default: begin
                    durum        <= BOS;
                    pc           <= '0;
                    emir         <= '0;
                    emir_gecerli <= 1'b0;
                    bitti        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emir_getirici.sv
// Directed bench for emir_getirici: hand-computed expectations checked with immediate assertions.
module tb_emir_getirici;

    logic        clk;
    logic        rst;
    logic        yukle_en;
    logic [3:0]  yukle_adres;
    logic [15:0] yukle_veri;
    logic [4:0]  program_uzunlugu;
    logic        basla;
    logic        tekrar;
    logic        dur;
    logic [15:0] emir;
    logic        emir_gecerli;
    logic [3:0]  pc;
    logic        bitti;

    int n_toplam = 0;
    int n_gecen  = 0;
    int n_hata   = 0;

    emir_getirici #(.ADRES_W(4), .EMIR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .yukle_en         (yukle_en),
        .yukle_adres      (yukle_adres),
        .yukle_veri       (yukle_veri),
        .program_uzunlugu (program_uzunlugu),
        .basla            (basla),
        .tekrar           (tekrar),
        .dur              (dur),
        .emir             (emir),
        .emir_gecerli     (emir_gecerli),
        .pc               (pc),
        .bitti            (bitti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_toplam++;
        assert (obs === exp) n_gecen++;
        else begin
            n_hata++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e_emir, input logic e_gec,
                           input logic [3:0] e_pc, input logic e_bitti);
        chk({tag, ".emir"}, 32'(emir), 32'(e_emir));
        chk({tag, ".gecerli"}, 32'(emir_gecerli), 32'(e_gec));
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".bitti"}, 32'(bitti), 32'(e_bitti));
    endtask

    task automatic yukle(input logic [3:0] a, input logic [15:0] d);
        yukle_en    = 1'b1;
        yukle_adres = a;
        yukle_veri  = d;
        step();
        yukle_en    = 1'b0;
    endtask

    task automatic baslat();
        basla = 1'b1;
        step();
        basla = 1'b0;
    endtask

    initial begin
        logic [15:0] prg [3];
        prg[0] = 16'h1234;
        prg[1] = 16'h5678;
        prg[2] = 16'h9ABC;

        rst = 1'b1;
        yukle_en = 1'b0;
        yukle_adres = '0;
        yukle_veri = '0;
        program_uzunlugu = '0;
        basla = 1'b0;
        tekrar = 1'b0;
        dur = 1'b0;
        step();
        step();
        chk_out("reset", 16'h0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        step();

        // 1) three-word program, no wrap
        for (int i = 0; i < 3; i++) yukle(4'(i), prg[i]);
        program_uzunlugu = 5'd3;
        tekrar = 1'b0;
        baslat();
        chk_out("t1.start", 16'h0, 1'b0, 4'd0, 1'b0);
        step(); chk_out("t1.w0", 16'h1234, 1'b1, 4'd1, 1'b0);
        step(); chk_out("t1.w1", 16'h5678, 1'b1, 4'd2, 1'b0);
        step(); chk_out("t1.w2", 16'h9ABC, 1'b1, 4'd0, 1'b1);
        step(); chk_out("t1.done", 16'h0, 1'b0, 4'd0, 1'b1);

        // 2) same program with wrap; then drop tekrar to end it
        tekrar = 1'b1;
        baslat();
        chk_out("t2.start", 16'h0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out($sformatf("t2.w%0d", i), prg[i % 3], 1'b1, 4'((i + 1) % 3), 1'b0);
        end
        tekrar = 1'b0;
        step(); chk_out("t2.end1", 16'h5678, 1'b1, 4'd2, 1'b0);
        step(); chk_out("t2.end2", 16'h9ABC, 1'b1, 4'd0, 1'b1);
        step(); chk_out("t2.done", 16'h0, 1'b0, 4'd0, 1'b1);

        // 3) stall for two cycles after the first word
        baslat();
        step(); chk_out("t3.w0", 16'h1234, 1'b1, 4'd1, 1'b0);
        dur = 1'b1;
        step(); chk_out("t3.st0", 16'h0, 1'b0, 4'd1, 1'b0);
        step(); chk_out("t3.st1", 16'h0, 1'b0, 4'd1, 1'b0);
        dur = 1'b0;
        step(); chk_out("t3.w1", 16'h5678, 1'b1, 4'd2, 1'b0);
        step(); chk_out("t3.w2", 16'h9ABC, 1'b1, 4'd0, 1'b1);
        step(); chk_out("t3.done", 16'h0, 1'b0, 4'd0, 1'b1);

        // 4a) zero length from BOS is ignored
        rst = 1'b1; step(); rst = 1'b0;
        program_uzunlugu = 5'd0;
        baslat();
        chk_out("t4.l0a", 16'h0, 1'b0, 4'd0, 1'b0);
        step(); chk_out("t4.l0b", 16'h0, 1'b0, 4'd0, 1'b0);

        // 4b) full-depth program with wrap: 15 is followed by 0
        for (int i = 0; i < 16; i++) yukle(4'(i), 16'h1000 + 16'(i));
        program_uzunlugu = 5'd16;
        tekrar = 1'b1;
        baslat();
        for (int i = 0; i < 18; i++) begin
            step();
            chk($sformatf("t4.full%0d.emir", i), 32'(emir), 32'(16'h1000 + 16'(i % 16)));
            chk($sformatf("t4.full%0d.pc", i), 32'(pc), 32'((i + 1) % 16));
        end
        chk("t4.full.bitti", 32'(bitti), 32'(0));

        // 5) writes during CALIS ignored; async reset mid-run
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 3; i++) yukle(4'(i), prg[i]);
        program_uzunlugu = 5'd3;
        tekrar = 1'b0;
        baslat();
        yukle(4'd1, 16'hDEAD);
        chk_out("t5.w0", 16'h1234, 1'b1, 4'd1, 1'b0);
        step(); chk_out("t5.w1", 16'h5678, 1'b1, 4'd2, 1'b0);
        step(); chk_out("t5.w2", 16'h9ABC, 1'b1, 4'd0, 1'b1);
        tekrar = 1'b1;
        baslat();
        step(); chk_out("t5.r0", 16'h1234, 1'b1, 4'd1, 1'b0);
        step(); chk_out("t5.r1", 16'h5678, 1'b1, 4'd2, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("t5.async", 16'h0, 1'b0, 4'd0, 1'b0);
        step();
        rst = 1'b0;
        tekrar = 1'b0;
        step(); chk_out("t5.idle", 16'h0, 1'b0, 4'd0, 1'b0);
        baslat();
        step(); chk_out("t5.re0", 16'h1234, 1'b1, 4'd1, 1'b0);
        step(); chk_out("t5.re1", 16'h5678, 1'b1, 4'd2, 1'b0);
        step(); chk_out("t5.re2", 16'h9ABC, 1'b1, 4'd0, 1'b1);

        // 6) write and start on the same edge from BITTI
        yukle_en = 1'b1;
        yukle_adres = 4'd0;
        yukle_veri = 16'hBEEF;
        basla = 1'b1;
        step();
        yukle_en = 1'b0;
        basla = 1'b0;
        chk_out("t6.start", 16'h0, 1'b0, 4'd0, 1'b0);
        step(); chk_out("t6.w0", 16'hBEEF, 1'b1, 4'd1, 1'b0);
        step(); chk_out("t6.w1", 16'h5678, 1'b1, 4'd2, 1'b0);

        $display("%0d/%0d checks passed", n_gecen, n_toplam);
        $finish;
    end

endmodule
